// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave):
// a registered request with a grant, followed by a read response for loads.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: E->M pipeline register plus a load/store FSM driving the data-memory port,
// with lane steering, load extension, misalignment detection and an access timeout.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flushM,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  RdE,
  input  logic [31:0] PCplus4E,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [2:0]  Funct3E,
  input  logic [1:0]  ResultSrcE,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic [31:0] PCplus4M,
  output logic [1:0]  ResultSrcM,
  output logic        RegWriteM,
  output logic [31:0] ReadDataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        busErrM,
  mem_stage_lsu_if.master dmem
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3)
      3'b000, 3'b100: r = 1'b0;
      3'b001, 3'b101: r = a[0];
      3'b010:         r = (a != 2'b00);
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e      state_q;
  logic [15:0] cnt_q;

  logic [31:0] alu_q, alu_d;
  logic [31:0] wd_q, wd_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  rsrc_q, rsrc_d;

  logic        stall_q, misalign_q, buserr_q;
  logic [31:0] rdata_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        memop_q_s, mis_q_s, memop_d_s, mis_d_s;

  // Next contents of the M register: advance (or bubble) only when not stalled.
  always_comb begin
    alu_d      = alu_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    pc4_d      = pc4_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    funct3_d   = funct3_q;
    rsrc_d     = rsrc_q;
    if (!stall_q) begin
      if (flushM) begin
        alu_d      = 32'd0;
        wd_d       = 32'd0;
        rd_d       = 5'd0;
        pc4_d      = 32'd0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        funct3_d   = 3'd0;
        rsrc_d     = 2'd0;
      end else begin
        alu_d      = ALUResultE;
        wd_d       = WriteDataE;
        rd_d       = RdE;
        pc4_d      = PCplus4E;
        regwrite_d = RegWriteE;
        memread_d  = MemReadE;
        memwrite_d = MemWriteE;
        funct3_d   = Funct3E;
        rsrc_d     = ResultSrcE;
      end
    end else begin
      alu_d = alu_q;
    end
  end

  assign memop_q_s = memread_q | memwrite_q;
  assign mis_q_s   = is_misaligned(funct3_q, alu_q[1:0]);
  assign memop_d_s = memread_d | memwrite_d;
  assign mis_d_s   = is_misaligned(funct3_d, alu_d[1:0]);

  // M register and load/store FSM; status outputs are computed one edge ahead so they are registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      alu_q      <= 32'd0;
      wd_q       <= 32'd0;
      rd_q       <= 5'd0;
      pc4_q      <= 32'd0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      funct3_q   <= 3'd0;
      rsrc_q     <= 2'd0;
      stall_q    <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      rdata_q    <= 32'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
    end else begin
      alu_q      <= alu_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
      pc4_q      <= pc4_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      funct3_q   <= funct3_d;
      rsrc_q     <= rsrc_d;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 16'd0;
          if (memop_q_s && !mis_q_s) begin
            state_q <= S_REQ;
            stall_q <= 1'b1;
            req_q   <= 1'b1;
            we_q    <= memwrite_q;
            addr_q  <= {alu_q[31:2], 2'b00};
            be_q    <= lane_be(funct3_q, alu_q[1:0]);
            wdata_q <= lane_wdata(funct3_q, wd_q);
          end else begin
            state_q    <= S_IDLE;
            stall_q    <= memop_d_s & ~mis_d_s;
            misalign_q <= memop_d_s & mis_d_s;
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
            if (we_q) begin
              state_q <= S_DONE;
              stall_q <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q  <= S_ABORT;
            buserr_q <= 1'b1;
            stall_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid) begin
            rdata_q <= load_ext(funct3_q, alu_q[1:0], dmem.dmem_rdata);
            state_q <= S_DONE;
            stall_q <= 1'b0;
            cnt_q   <= 16'd0;
          end else if (cnt_q == TO_LAST) begin
            state_q  <= S_ABORT;
            buserr_q <= 1'b1;
            stall_q  <= 1'b0;
            cnt_q    <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE, S_ABORT: begin
          state_q    <= S_IDLE;
          cnt_q      <= 16'd0;
          stall_q    <= memop_d_s & ~mis_d_s;
          misalign_q <= memop_d_s & mis_d_s;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 16'd0;
          stall_q <= 1'b0;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= 32'd0;
          be_q    <= 4'd0;
          wdata_q <= 32'd0;
        end
      endcase
    end
  end

  assign ALUResultM = alu_q;
  assign RdM        = rd_q;
  assign PCplus4M   = pc4_q;
  assign ResultSrcM = rsrc_q;
  assign RegWriteM  = regwrite_q & ~misalign_q & ~buserr_q;
  assign ReadDataM  = rdata_q;
  assign stallM     = stall_q;
  assign misalignM  = misalign_q;
  assign busErrM    = buserr_q;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule
